reg_bank_readout: RTL and testbench
===================================

Name: reg_bank_readout

Overview:
Read-side companion to the team's enable-gated P-bit storage registers. On a START pulse it takes a coherent snapshot of a flattened bank of N registers, then streams the words out one per handshake on a valid/ready interface, tagged with index and last flag. It sits between the register bank and the debug/host readback path.

Parameters:
P, 32, width of each register word
N, 8, number of registers in the bank (1..2^AW-2)
AW, 4, width of OUT_IDX

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  reset, synchronous, active-high
START  input  1  readout request, sampled only in IDLE
BANK_DATA  input  N*P  flattened register outputs; word i = BANK_DATA[i*P +: P]
OUT_DATA  output  P  current word
OUT_IDX  output  AW  index of current word
OUT_VALID  output  1  OUT_DATA/OUT_IDX/OUT_LAST valid
OUT_READY  input  1  downstream accepts word
OUT_LAST  output  1  current word is final word of the readout
BUSY  output  1  readout in progress
DONE  output  1  one-cycle pulse after final handshake

Behaviour:
- Reset: RST is synchronous, active-high. On any edge with RST=1: state IDLE, shadow cleared to 0, index counter 0; OUT_DATA=0, OUT_IDX=0, OUT_VALID=0, OUT_LAST=0, BUSY=0, DONE=0. RST overrides every other input; reset mid-stream aborts with no DONE.
- All outputs are registered. No combinational path from OUT_READY or START to any output.
- States: IDLE, SEND, FIN.
- IDLE: at an edge with START=1, shadow <= BANK_DATA (all N words, same edge), idx <= 0, state -> SEND. OUT_VALID=1, BUSY=1, OUT_DATA=word 0, OUT_IDX=0 from the next cycle. Latency START -> first OUT_VALID = 1 cycle.
- SEND: handshake = OUT_VALID & OUT_READY at a rising edge.
  - No handshake: OUT_DATA, OUT_IDX, OUT_LAST, OUT_VALID hold.
  - Handshake on a non-last word: idx+1; the next word is presented the following cycle and OUT_VALID stays 1 (no bubble). OUT_READY held high gives 1 word/cycle.
  - OUT_LAST=1 exactly while idx = final index (N-1 without the optional feature).
  - Handshake on the last word: OUT_VALID=0, OUT_LAST=0, BUSY=0, DONE=1 next cycle, state -> FIN.
- FIN: one cycle. DONE=1, then DONE=0 and state -> IDLE. START during FIN is ignored.
- START while in SEND or FIN is ignored. It is not queued.
- BANK_DATA changes after the snapshot edge do not affect the streamed words.
- N=1: first word has OUT_LAST=1.
- idx never exceeds the final index. OUT_IDX is zero-extended to AW.

Optional Feature:
READOUT_CHECKSUM_EN
- Defined: after word N-1 one extra word is sent, with OUT_IDX=N and OUT_DATA = XOR of all N snapshot words.
  - The XOR is accumulated at snapshot time and registered.
  - OUT_LAST moves to the checksum word. Word N-1 has OUT_LAST=0.
  - DONE follows the checksum handshake.
  - Total of N+1 handshakes.
- Not defined: exactly N words are sent, OUT_LAST is on idx N-1, and no checksum logic is generated.

Test Plan:
1. Basic stream: N=8, P=32, BANK_DATA word i = 32'hA000_0000+i, START for 1 cycle, OUT_READY=1 -> OUT_VALID rises 1 cycle after START; 8 consecutive cycles carry idx 0..7 with data A0000000..A0000007; OUT_LAST only on idx 7; DONE pulses 1 cycle after the idx-7 handshake; BUSY is low in the DONE cycle.
2. Backpressure: OUT_READY low 3 cycles while idx 2 is presented, and alternating afterwards -> idx 2 data/idx/valid stable all 3 cycles; no word skipped or duplicated; 8 handshakes total.
3. Snapshot coherence: START, then BANK_DATA changes to all 32'hFFFF_FFFF on the next cycle -> every streamed word equals the pre-change value.
4. Ignored START: pulse START at idx 4 and during FIN -> exactly one readout of 8 words, one DONE; IDLE afterwards with outputs 0.
5. Reset mid-operation: RST=1 for 1 cycle at idx 5 -> next cycle all outputs 0 and no DONE; a new START gives a full readout from idx 0.
6. Checksum (READOUT_CHECKSUM_EN defined): words 1,2,4,8,16,32,64,128 -> 9 handshakes; idx 8 carries 32'h0000_00FF with OUT_LAST=1; idx 7 has OUT_LAST=0.

Source files
------------

// File: rtl/reg_bank_readout.sv
// Snapshot-and-stream readout of a flattened register bank over valid/ready.
// Optional READOUT_CHECKSUM_EN appends an XOR checksum word after the bank words.
module reg_bank_readout #(
   parameter int P  = 32,
   parameter int N  = 8,
   parameter int AW = 4
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           START,
   input  logic [N*P-1:0] BANK_DATA,
   output logic [P-1:0]   OUT_DATA,
   output logic [AW-1:0]  OUT_IDX,
   output logic           OUT_VALID,
   input  logic           OUT_READY,
   output logic           OUT_LAST,
   output logic           BUSY,
   output logic           DONE
);

   typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

`ifdef READOUT_CHECKSUM_EN
   localparam int unsigned NW = N + 1;
`else
   localparam int unsigned NW = N;
`endif
   localparam logic [AW-1:0] LAST_IDX = AW'(NW - 1);

   state_t         state, state_nxt;
   logic [N*P-1:0] shadow, shadow_nxt;
   logic [AW-1:0]  idx_nxt;
   logic [P-1:0]   data_nxt;
   logic           valid_nxt, last_nxt, busy_nxt, done_nxt;

`ifdef READOUT_CHECKSUM_EN
   logic [P-1:0]   csum, csum_nxt, bank_xor;

   always_comb begin
      bank_xor = '0;
      for (int unsigned k = 0; k < N; k++)
         bank_xor = bank_xor ^ BANK_DATA[k*P +: P];
   end
`endif

   function automatic logic [P-1:0] word_at(input logic [N*P-1:0] bank,
                                             input logic [AW-1:0]  i);
      word_at = '0;
      for (int unsigned k = 0; k < N; k++)
         if (AW'(k) == i) word_at = bank[k*P +: P];
   endfunction

   // OUT_IDX doubles as the stream index register.
   always_comb begin
      state_nxt  = state;
      shadow_nxt = shadow;
      idx_nxt    = OUT_IDX;
      data_nxt   = OUT_DATA;
      valid_nxt  = OUT_VALID;
      last_nxt   = OUT_LAST;
      busy_nxt   = BUSY;
      done_nxt   = 1'b0;
`ifdef READOUT_CHECKSUM_EN
      csum_nxt   = csum;
`endif
      case (state)
         IDLE: begin
            if (START) begin
               shadow_nxt = BANK_DATA;
`ifdef READOUT_CHECKSUM_EN
               csum_nxt   = bank_xor;
`endif
               idx_nxt    = '0;
               data_nxt   = word_at(BANK_DATA, '0);
               valid_nxt  = 1'b1;
               busy_nxt   = 1'b1;
               last_nxt   = (LAST_IDX == '0);
               state_nxt  = SEND;
            end
         end
         SEND: begin
            if (OUT_VALID && OUT_READY) begin
               if (OUT_IDX == LAST_IDX) begin
                  idx_nxt   = '0;
                  data_nxt  = '0;
                  valid_nxt = 1'b0;
                  last_nxt  = 1'b0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  state_nxt = FIN;
               end else begin
                  idx_nxt  = OUT_IDX + 1'b1;
                  last_nxt = (idx_nxt == LAST_IDX);
`ifdef READOUT_CHECKSUM_EN
                  if (idx_nxt == AW'(N)) data_nxt = csum;
                  else                   data_nxt = word_at(shadow, idx_nxt);
`else
                  data_nxt = word_at(shadow, idx_nxt);
`endif
               end
            end
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         shadow    <= '0;
         OUT_IDX   <= '0;
         OUT_DATA  <= '0;
         OUT_VALID <= 1'b0;
         OUT_LAST  <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         state     <= state_nxt;
         shadow    <= shadow_nxt;
         OUT_IDX   <= idx_nxt;
         OUT_DATA  <= data_nxt;
         OUT_VALID <= valid_nxt;
         OUT_LAST  <= last_nxt;
         BUSY      <= busy_nxt;
         DONE      <= done_nxt;
`ifdef READOUT_CHECKSUM_EN
         csum      <= csum_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_reg_bank_readout.sv
// Bench for reg_bank_readout: table vectors, directed corner sequences and
// randomized traffic against a queue-based readout model; also an N=1 instance.
module tb_reg_bank_readout;

   localparam int P  = 32;
   localparam int N  = 8;
   localparam int AW = 4;
`ifdef READOUT_CHECKSUM_EN
   localparam int NW = N + 1;
`else
   localparam int NW = N;
`endif

   logic           CLK = 1'b0;
   logic           RST, START, OUT_READY;
   logic [N*P-1:0] BANK_DATA;
   logic [P-1:0]   OUT_DATA;
   logic [AW-1:0]  OUT_IDX;
   logic           OUT_VALID, OUT_LAST, BUSY, DONE;

   logic [P-1:0]   bank1;
   logic [P-1:0]   o1_data;
   logic [AW-1:0]  o1_idx;
   logic           o1_valid, o1_last, o1_busy, o1_done;

   assign bank1 = BANK_DATA[P-1:0];

   always #5 CLK = ~CLK;

   reg_bank_readout #(.P(P), .N(N), .AW(AW)) dut (
      .CLK(CLK), .RST(RST), .START(START), .BANK_DATA(BANK_DATA),
      .OUT_DATA(OUT_DATA), .OUT_IDX(OUT_IDX), .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST), .BUSY(BUSY), .DONE(DONE)
   );

   reg_bank_readout #(.P(P), .N(1), .AW(AW)) dut1 (
      .CLK(CLK), .RST(RST), .START(START), .BANK_DATA(bank1),
      .OUT_DATA(o1_data), .OUT_IDX(o1_idx), .OUT_VALID(o1_valid),
      .OUT_READY(OUT_READY), .OUT_LAST(o1_last), .BUSY(o1_busy), .DONE(o1_done)
   );

   typedef struct packed {
      logic [AW-1:0] idx;
      logic [P-1:0]  data;
      logic          last;
   } item_t;

   typedef struct {
      bit            start;
      bit            ready;
      bit            valid;
      int unsigned   idx;
      logic [P-1:0]  data;
      bit            last;
      bit            busy;
      bit            done;
   } vec_t;

   int    checks = 0, failures = 0;
   int    dut_hs = 0, done_cnt = 0;
   item_t q[$];
   bit    m_fin = 0;
   vec_t  tbl[$];

   function automatic logic [63:0] pack(input bit done, input bit busy, input bit last,
                                        input bit valid, input logic [AW-1:0] idx,
                                        input logic [P-1:0] data);
      pack = 64'({done, busy, last, valid, idx, data});
   endfunction

   function automatic logic [N*P-1:0] ramp(input logic [P-1:0] base);
      ramp = '0;
      for (int i = 0; i < N; i++) ramp[i*P +: P] = base + P'(i);
   endfunction

   function automatic logic [P-1:0] xor_words(input logic [N*P-1:0] bk);
      xor_words = '0;
      for (int i = 0; i < N; i++) xor_words = xor_words ^ bk[i*P +: P];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: a readout is the queue of words captured at START; each accepted
   // word pops one entry, and the cycle after the queue empties is the DONE cycle.
   task automatic step(input bit st, input bit rdy, input bit rs, input logic [N*P-1:0] bk);
      logic [63:0] exp;
      START = st; OUT_READY = rdy; RST = rs; BANK_DATA = bk;
      #1;
      if (!rs && OUT_VALID && rdy) dut_hs++;
      if (rs) begin
         q.delete();
         m_fin = 0;
      end else if (m_fin) begin
         m_fin = 0;
      end else if (q.size() == 0) begin
         if (st) begin
            for (int i = 0; i < N; i++)
               q.push_back('{idx: AW'(i), data: bk[i*P +: P], last: (i == NW - 1)});
            if (NW > N) q.push_back('{idx: AW'(N), data: xor_words(bk), last: 1'b1});
         end
      end else if (rdy) begin
         void'(q.pop_front());
         if (q.size() == 0) m_fin = 1;
      end
      @(posedge CLK);
      #1;
      if (DONE) done_cnt++;
      if (q.size() != 0) exp = pack(1'b0, 1'b1, q[0].last, 1'b1, q[0].idx, q[0].data);
      else               exp = pack(m_fin, 1'b0, 1'b0, 1'b0, '0, '0);
      check("outputs", pack(DONE, BUSY, OUT_LAST, OUT_VALID, OUT_IDX, OUT_DATA), exp);
   endtask

   task automatic drain(input logic [N*P-1:0] bk);
      for (int k = 0; k < 60 && (q.size() != 0 || m_fin); k++) step(0, 1, 0, bk);
   endtask

   initial begin
      logic [N*P-1:0] bk, bk2;
      int d0, h0;

      START = 0; OUT_READY = 0; RST = 1; BANK_DATA = '0;
      @(posedge CLK); #1;
      step(0, 0, 1, '0);
      check("reset", pack(DONE, BUSY, OUT_LAST, OUT_VALID, OUT_IDX, OUT_DATA), 64'h0);

      // Basic stream table
      bk = ramp(32'hA000_0000);
      tbl.push_back('{1, 1, 1, 0, 32'hA000_0000, (NW == 1), 1, 0});
      for (int i = 1; i < NW; i++)
         tbl.push_back('{0, 1, 1, i, (i < N) ? 32'hA000_0000 + P'(i) : xor_words(bk),
                         (i == NW - 1), 1, 0});
      tbl.push_back('{0, 1, 0, 0, '0, 0, 0, 1});
      tbl.push_back('{0, 1, 0, 0, '0, 0, 0, 0});
      foreach (tbl[r]) begin
         step(tbl[r].start, tbl[r].ready, 0, bk);
         check($sformatf("table row %0d", r),
               pack(DONE, BUSY, OUT_LAST, OUT_VALID, OUT_IDX, OUT_DATA),
               pack(tbl[r].done, tbl[r].busy, tbl[r].last, tbl[r].valid,
                    AW'(tbl[r].idx), tbl[r].data));
      end

      // Backpressure: stall at idx 2 for 3 cycles, then alternate ready
      bk = ramp(32'h1234_0000);
      h0 = dut_hs;
      step(1, 1, 0, bk);
      step(0, 1, 0, bk);
      step(0, 1, 0, bk);
      for (int i = 0; i < 3; i++) step(0, 0, 0, bk);
      for (int i = 0; i < 60 && (q.size() != 0 || m_fin); i++) step(0, i[0], 0, bk);
      check("backpressure handshakes", 64'(dut_hs - h0), 64'(NW));

      // Snapshot coherence: bank changes right after START
      bk = ramp(32'h5500_0100);
      bk2 = '1;
      step(1, 1, 0, bk);
      drain(bk2);

      // Ignored START at idx 4 and during FIN
      bk = ramp(32'h0BAD_0000);
      d0 = done_cnt;
      step(1, 1, 0, bk);
      for (int i = 0; i < 4; i++) step(0, 1, 0, bk);
      step(1, 1, 0, bk);
      for (int k = 0; k < 40 && !m_fin; k++) step(0, 1, 0, bk);
      step(1, 1, 0, bk);
      step(0, 0, 0, bk);
      check("one DONE", 64'(done_cnt - d0), 64'd1);

      // Reset mid-stream at idx 5
      bk = ramp(32'h7700_0000);
      d0 = done_cnt;
      step(1, 1, 0, bk);
      for (int i = 0; i < 5; i++) step(0, 1, 0, bk);
      step(0, 0, 1, bk);
      step(0, 0, 0, bk);
      step(0, 0, 0, bk);
      check("no DONE after reset", 64'(done_cnt - d0), 64'd0);
      step(1, 1, 0, bk);
      drain(bk);

      // Checksum-pattern words 1,2,4..128
      bk = '0;
      for (int i = 0; i < N; i++) bk[i*P +: P] = P'(1) << i;
      step(1, 1, 0, bk);
      drain(bk);

      // N=1 boundary on the second instance
      bk = ramp(32'hC0DE_0000);
      step(0, 0, 1, bk);
      step(1, 0, 0, bk);
      check("n1 first word",
            pack(o1_done, o1_busy, o1_last, o1_valid, o1_idx, o1_data),
            pack(0, 1, (NW == N), 1, '0, 32'hC0DE_0000));
`ifdef READOUT_CHECKSUM_EN
      step(0, 1, 0, bk);
      check("n1 checksum word",
            pack(o1_done, o1_busy, o1_last, o1_valid, o1_idx, o1_data),
            pack(0, 1, 1, 1, AW'(1), 32'hC0DE_0000));
`endif
      step(0, 1, 0, bk);
      check("n1 done",
            pack(o1_done, o1_busy, o1_last, o1_valid, o1_idx, o1_data),
            pack(1, 0, 0, 0, '0, '0));
      step(0, 1, 0, bk);
      check("n1 idle",
            pack(o1_done, o1_busy, o1_last, o1_valid, o1_idx, o1_data),
            pack(0, 0, 0, 0, '0, '0));

      // Randomized traffic
      step(0, 0, 1, bk);
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 9) == 0)
            for (int i = 0; i < N; i++) bk[i*P +: P] = $urandom;
         step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6,
              $urandom_range(0, 99) < 2, bk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
